// File: rtl/uart_word_sequencer_pkg.sv
// Shared encodings for the UART word sequencer: byte-class tags, FSM states
// and default widths.
package uart_word_sequencer_pkg;

  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_WORD_WIDTH = 13;
  localparam int DEF_ADDR_WIDTH = 5;

  // Tags taken from the top bits of each received byte.
  localparam logic [1:0] TAG_ADDR = 2'b11;
  localparam logic [1:0] TAG_HIGH = 2'b10;
  localparam logic       TAG_LOW  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNLOAD = 2'd1,
    ST_GAP    = 2'd2,
    ST_DECODE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_ADDR = 2'd0,
    CLS_LOW  = 2'd1,
    CLS_HIGH = 2'd2
  } byte_class_e;

endpackage

// File: rtl/uart_word_sequencer_if.sv
// Bundle between the UART receive FIFO, the sequencer and the register file,
// plus the sequencer state for observation.
interface uart_word_sequencer_if
  import uart_word_sequencer_pkg::*;
#(
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  // Handshake: byte_rdy is a level meaning din holds a valid FIFO head byte;
  // a one-cycle unload_uart pulse pops it, and din/byte_rdy then reflect the
  // next entry. wr_en is a one-cycle strobe with wr_addr/wr_data valid only
  // while it is high; the register file has no back-pressure.
  logic                  byte_rdy;
  logic [BYTE_WIDTH-1:0] din;
  logic                  unload_uart;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  busy;
  logic [7:0]            err_cnt;
  state_e                state;

  modport slave (
    input  byte_rdy, din,
    output unload_uart, wr_en, wr_addr, wr_data, busy, err_cnt, state
  );

  modport master (
    output byte_rdy, din,
    input  unload_uart, wr_en, wr_addr, wr_data, busy, err_cnt, state
  );

endinterface

// File: rtl/uart_frame_decode.sv
// Combinational classification of a received byte into ADDR / LOW / HIGH
// and extraction of the payload fields.
module uart_frame_decode
  import uart_word_sequencer_pkg::*;
#(
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [BYTE_WIDTH-1:0] din,
  output byte_class_e           cls,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [6:0]            low_payload,
  output logic [5:0]            high_payload
);

  always_comb begin
    cls = CLS_HIGH;
    if (din[7] == TAG_LOW) begin
      cls = CLS_LOW;
    end else if (din[7:6] == TAG_ADDR) begin
      cls = CLS_ADDR;
    end else if (din[7:6] == TAG_HIGH) begin
      cls = CLS_HIGH;
    end
  end

  assign addr         = din[ADDR_WIDTH-1:0];
  assign low_payload  = din[6:0];
  assign high_payload = din[5:0];

endmodule

// File: rtl/uart_word_sequencer.sv
// Pops bytes from a UART FIFO, pairs LOW/HIGH halves into signed words and
// writes them to auto-incrementing register addresses.
module uart_word_sequencer
  import uart_word_sequencer_pkg::*;
#(
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = 50000,
  parameter int UNLOAD_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_word_sequencer_if.slave  bus
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (UNLOAD_GAP > 1) ? $clog2(UNLOAD_GAP) : 1;

  state_e                state_q, state_d;
  logic [GAP_W-1:0]      gap_q;
  logic [BYTE_WIDTH-1:0] byte_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addr_valid_q;
  logic [6:0]            low_q;
  logic                  low_valid_q;
  logic [TO_W-1:0]       to_q;
  logic [7:0]            err_q;

  byte_class_e           cls;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [6:0]            dec_low;
  logic [5:0]            dec_high;

  logic capture, timeout_hit, gap_done;
  logic do_write, do_err, do_unload;

  uart_frame_decode #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .din          (byte_q),
    .cls          (cls),
    .addr         (dec_addr),
    .low_payload  (dec_low),
    .high_payload (dec_high)
  );

  assign capture     = (state_q == ST_IDLE) && bus.byte_rdy;
  assign timeout_hit = (state_q == ST_IDLE) && low_valid_q && (to_q == TO_W'(TIMEOUT));
  assign gap_done    = (gap_q == GAP_W'(UNLOAD_GAP - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are gated by rst so a reset landing in UNLOAD or DECODE neither
  // pops the FIFO nor writes a register.
  always_comb begin
    state_d   = state_q;
    do_unload = 1'b0;
    do_write  = 1'b0;
    do_err    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.byte_rdy) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        do_unload = !rst;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        unique case (cls)
          CLS_ADDR: do_err = 1'b0;
          CLS_LOW:  do_err = !addr_valid_q || low_valid_q;
          CLS_HIGH: begin
            do_write = addr_valid_q && low_valid_q && !rst;
            do_err   = !(addr_valid_q && low_valid_q);
          end
          default:  do_err = 1'b0;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q        <= '0;
      byte_q       <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      low_q        <= '0;
      low_valid_q  <= 1'b0;
      to_q         <= '0;
      err_q        <= '0;
    end else begin
      if (capture) byte_q <= bus.din;

      if (state_q == ST_UNLOAD) begin
        gap_q <= '0;
      end else if (state_q == ST_GAP) begin
        gap_q <= gap_q + GAP_W'(1);
      end

      // Idle-time watchdog for a LOW byte waiting on its HIGH half.
      if (capture || !low_valid_q || timeout_hit) begin
        to_q <= '0;
      end else if (state_q == ST_IDLE) begin
        to_q <= to_q + TO_W'(1);
      end

      if (timeout_hit) low_valid_q <= 1'b0;

      if (state_q == ST_DECODE) begin
        unique case (cls)
          CLS_ADDR: begin
            addr_q       <= dec_addr;
            addr_valid_q <= 1'b1;
            low_valid_q  <= 1'b0;
          end
          CLS_LOW: begin
            if (addr_valid_q) begin
              low_q       <= dec_low;
              low_valid_q <= 1'b1;
            end
          end
          CLS_HIGH: begin
            if (do_write) begin
              low_valid_q <= 1'b0;
              addr_q      <= addr_q + ADDR_WIDTH'(1);
            end
          end
          default: low_valid_q <= low_valid_q;
        endcase
      end

      if ((do_err || timeout_hit) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign bus.unload_uart = do_unload;
  assign bus.wr_en       = do_write;
  assign bus.wr_addr     = do_write ? addr_q : '0;
  assign bus.wr_data     = do_write ? WORD_WIDTH'($signed({dec_high, low_q})) : '0;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.err_cnt     = err_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_uart_word_sequencer.sv
// Directed bench for uart_word_sequencer: FIFO model on the byte side,
// write scoreboard on the register side.
module tb_uart_word_sequencer;
  import uart_word_sequencer_pkg::*;

  localparam int BW  = 8;
  localparam int WW  = 13;
  localparam int AW  = 5;
  localparam int TO  = 100;
  localparam int GAP = 2;
  localparam int SW  = AW + WW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_word_sequencer_if #(.BYTE_WIDTH(BW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  uart_word_sequencer #(
    .BYTE_WIDTH(BW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW),
    .TIMEOUT(TO), .UNLOAD_GAP(GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- state ----------------
  logic [BW-1:0] fifo_q[$];
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] obs_q[$];
  int            unl_cyc[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int unl_count = 0;
  int wide_viol = 0;
  int excl_viol = 0;
  logic prev_unl = 1'b0;
  int base, mn, mx, seen, k;

  // FIFO model: pops on an observed unload pulse, presents the new head.
  initial begin
    bus.byte_rdy = 1'b0;
    bus.din      = '0;
    forever begin
      @(negedge clk);
      if (bus.unload_uart && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.byte_rdy = (fifo_q.size() > 0);
      bus.din      = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.wr_en) obs_q.push_back({bus.wr_addr, bus.wr_data});
      if (bus.unload_uart) begin
        unl_count++;
        unl_cyc.push_back(cyc);
        if (prev_unl) wide_viol++;
      end
      if (bus.wr_en && bus.unload_uart) excl_viol++;
      prev_unl = bus.unload_uart;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!(fifo_q.size() == 0 && !bus.busy) && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= budget) check("drain_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [SW-1:0] wr(input int a, input int d);
    return {AW'(a), WW'(d)};
  endfunction

  task automatic check_writes(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   bus.busy, 0);
    check("rst_wr_en",  bus.wr_en, 0);
    check("rst_unload", bus.unload_uart, 0);
    check("rst_err",    bus.err_cnt, 0);
    check("rst_state",  bus.state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;

    // Basic word: addr 3, LOW 0x55, HIGH 0x0A -> 13'h0555.
    push(8'hC3); push(8'h55); push(8'h8A);
    exp_q.push_back(wr(3, 'h0555));
    drain(100);
    check_writes("basic");
    check("basic_err", bus.err_cnt, 0);

    // Address wrap 31 -> 0.
    push(8'hDF); push(8'h01); push(8'h80); push(8'h7F); push(8'hBF);
    exp_q.push_back(wr(31, 'h0001));
    exp_q.push_back(wr(0, 'h1FFF));
    drain(100);
    check_writes("wrap");
    check("wrap_err", bus.err_cnt, 0);

    // Orphan HIGH and LOW with no address after reset.
    do_reset();
    push(8'h81);
    drain(100);
    check("orphan_err", bus.err_cnt, 1);
    push(8'h12);
    drain(100);
    check("noaddr_low_err", bus.err_cnt, 2);
    check_writes("orphan");

    // LOW overwritten by a second LOW, then HIGH with no pending LOW.
    push(8'hC5); push(8'h10); push(8'h22); push(8'h83); push(8'h85);
    exp_q.push_back(wr(5, 'h01A2));
    drain(200);
    check_writes("ovw");
    check("ovw_err", bus.err_cnt, 4);

    // Timeout on a pending LOW; address kept afterwards.
    do_reset();
    push(8'hC1); push(8'h40);
    drain(100);
    idle(TO - 5);
    check("to_early", bus.err_cnt, 0);
    idle(10);
    check("to_fire", bus.err_cnt, 1);
    push(8'h9F);
    drain(100);
    check_writes("to_high");
    check("to_high_err", bus.err_cnt, 2);
    push(8'h03); push(8'h80);
    exp_q.push_back(wr(1, 'h0003));
    drain(100);
    check_writes("to_addr_kept");
    check("to_kept_err", bus.err_cnt, 2);

    // 20 back-to-back bytes with byte_rdy held high.
    do_reset();
    unl_cyc.delete();
    base = unl_count;
    push(8'hC0);
    for (int i = 0; i < 9; i++) begin
      push(8'(i));
      push(8'h80 | 8'(i));
      exp_q.push_back(wr(i, (i << 7) | i));
    end
    push(8'h11);
    drain(400);
    check("stream_unloads", unl_count - base, 20);
    mn = 1000;
    mx = 0;
    for (int j = 1; j < unl_cyc.size(); j++) begin
      if (unl_cyc[j] - unl_cyc[j-1] < mn) mn = unl_cyc[j] - unl_cyc[j-1];
      if (unl_cyc[j] - unl_cyc[j-1] > mx) mx = unl_cyc[j] - unl_cyc[j-1];
    end
    check("stream_gap_min", mn, GAP + 3);
    check("stream_gap_max", mx, GAP + 3);
    check_writes("stream");
    check("stream_err", bus.err_cnt, 0);

    // Error counter saturates at 255.
    do_reset();
    repeat (260) push(8'hA5);
    drain(1500);
    check("sat_err", bus.err_cnt, 255);
    check_writes("sat");

    // Reset during the GAP that follows the HIGH byte.
    do_reset();
    push(8'hC2); push(8'h11); push(8'h90);
    seen = 0;
    k = 0;
    while (seen < 3 && k < 100) begin
      @(negedge clk);
      if (bus.state == ST_UNLOAD) seen++;
      k++;
    end
    if (seen < 3) check("gap_wait_timeout", 1, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("gap_rst_busy",    bus.busy, 0);
    check("gap_rst_wr_en",   bus.wr_en, 0);
    check("gap_rst_unload",  bus.unload_uart, 0);
    check("gap_rst_wr_addr", bus.wr_addr, 0);
    check("gap_rst_wr_data", bus.wr_data, 0);
    check("gap_rst_err",     bus.err_cnt, 0);
    check("gap_rst_state",   bus.state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;
    idle(10);
    check_writes("gap_rst");

    check("excl_wr_unload", excl_viol, 0);
    check("unload_width",   wide_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
